// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronized input, mid-bit sampling, break detection.
// All outputs come straight from registers so rx never reaches an output combinationally.
module uart_rx #(
    parameter int CLKS_PER_BIT = 625
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       busy_o,
    output logic [2:0] state_o
);

    localparam int N  = CLKS_PER_BIT;
    localparam int H  = N / 2;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            s1_q, s2_q;

    // Synchronizer resets to the idle level so a reset never looks like a start edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            s1_q    <= rx_i;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!s2_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            // Re-check the line half a bit in, so short glitches are dropped silently.
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = s2_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = s2_q;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (s2_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            // A held-low line must go high before another frame can begin.
            BREAK: begin
                cnt_d = '0;
                if (s2_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign busy_o      = (state_q != IDLE);
    assign state_o     = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: builds a per-cycle rx/reset waveform, predicts outputs from frame
// timing rules, then drives the waveform and compares every cycle plus a few fixed points.
module tb_uart_rx;

    localparam int N = 16;
    localparam int H = N / 2;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frameErr;
    logic       busy;
    logic [2:0] state;

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .rx_i       (rx),
        .data_o     (data),
        .valid_o    (valid),
        .frame_err_o(frameErr),
        .busy_o     (busy),
        .state_o    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waveform: entry k is what the DUT captures at clock edge k.
    bit rxQ[$];
    bit rstQ[$];
    bit eff[];

    bit        expV[];
    bit        expF[];
    bit        expB[];
    logic [7:0] expD[];
    int        expS[];

    typedef struct {
        int edgeIdx;
        int kind;
        int val;
    } lit_t;
    lit_t litQ[$];

    int errCount   = 0;
    int checkCount = 0;
    int T;

    task automatic pushIdle(input int n, input bit level);
        for (int k = 0; k < n; k++) begin
            rxQ.push_back(level);
            rstQ.push_back(1'b0);
        end
    endtask

    task automatic pushReset(input int n);
        for (int k = 0; k < n; k++) begin
            rxQ.push_back(1'b1);
            rstQ.push_back(1'b1);
        end
    endtask

    // One 10-bit frame; from cycle cutAt on the line goes high and reset pulses once.
    task automatic sendFrame(input logic [7:0] b, input bit stopBit, input int cutAt);
        int bitIdx;
        bit v;
        for (int k = 0; k < 10 * N; k++) begin
            bitIdx = k / N;
            if (bitIdx == 0)      v = 1'b0;
            else if (bitIdx <= 8) v = b[bitIdx-1];
            else                  v = stopBit;
            if (cutAt >= 0 && k >= cutAt) v = 1'b1;
            rxQ.push_back(v);
            rstQ.push_back(cutAt >= 0 && k == cutAt);
        end
    endtask

    task automatic addLit(input int edgeIdx, input int kind, input int val);
        lit_t l;
        l.edgeIdx = edgeIdx;
        l.kind    = kind;
        l.val     = val;
        litQ.push_back(l);
    endtask

    function automatic bit effAt(input int x);
        if (x < 0 || x >= T) return 1'b1;
        return eff[x];
    endfunction

    // Frame-level prediction: find accepted start edges, then place each sample
    // at its mid-bit edge and derive pulses, data and state spans from that.
    task automatic buildModel();
        int e, s, chk, stopE, endE, kind, k;
        logic [7:0] cur, by;
        T    = rxQ.size();
        eff  = new[T];
        expV = new[T];
        expF = new[T];
        expB = new[T];
        expD = new[T];
        expS = new[T];
        for (int i = 0; i < T; i++) begin
            eff[i]  = rxQ[i];
            expV[i] = 1'b0;
            expF[i] = 1'b0;
            expB[i] = 1'b0;
            expD[i] = 8'h00;
            expS[i] = 0;
        end
        for (int i = 0; i < T; i++) begin
            if (rstQ[i]) begin
                eff[i] = 1'b1;
                if (i > 0) eff[i-1] = 1'b1;
            end
        end
        e   = 0;
        cur = 8'h00;
        by  = 8'h00;
        while (e < T) begin
            if (rstQ[e]) begin
                cur     = 8'h00;
                expD[e] = cur;
                e++;
                continue;
            end
            expD[e] = cur;
            if (effAt(e - 2)) begin
                e++;
                continue;
            end
            s     = e;
            chk   = s + H;
            stopE = s + H + 9 * N;
            if (effAt(chk - 2)) begin
                kind = 0;
                endE = chk;
            end else begin
                for (int i = 0; i < 8; i++) by[i] = effAt(s + H + (i + 1) * N - 2);
                if (effAt(stopE - 2)) begin
                    kind = 1;
                    endE = stopE;
                end else begin
                    kind = 2;
                    endE = stopE + 1;
                    while (endE < T && !effAt(endE - 2)) endE++;
                end
            end
            k = s;
            while (k <= endE && k < T) begin
                if (rstQ[k]) break;
                expD[k] = cur;
                if (k < endE) begin
                    expB[k] = 1'b1;
                    if (k < s + H)                         expS[k] = 1;
                    else if (k < s + H + 8 * N)            expS[k] = 2;
                    else if (k < stopE)                    expS[k] = 3;
                    else                                   expS[k] = 4;
                    if (kind == 2 && k == stopE) expF[k] = 1'b1;
                end else if (kind == 1) begin
                    cur     = by;
                    expD[k] = cur;
                    expV[k] = 1'b1;
                end
                k++;
            end
            e = k;
        end
    endtask

    task automatic cmp(input string name, input int e, input int act, input int exp);
        checkCount++;
        if (act != exp) begin
            errCount++;
            $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", name, e, act, exp);
        end
    endtask

    task automatic applyStimulus(input int e);
        rx    = rxQ[e];
        reset = rstQ[e];
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int e);
        cmp("valid", e, int'(valid), int'(expV[e]));
        cmp("frame_err", e, int'(frameErr), int'(expF[e]));
        cmp("data", e, int'(data), int'(expD[e]));
        cmp("busy", e, int'(busy), int'(expB[e]));
        cmp("state", e, int'(state), expS[e]);
        foreach (litQ[i]) begin
            if (litQ[i].edgeIdx == e) begin
                case (litQ[i].kind)
                    0:       cmp("pin_valid", e, int'(valid), litQ[i].val);
                    1:       cmp("pin_frame_err", e, int'(frameErr), litQ[i].val);
                    2:       cmp("pin_data", e, int'(data), litQ[i].val);
                    3:       cmp("pin_state", e, int'(state), litQ[i].val);
                    default: cmp("pin_busy", e, int'(busy), litQ[i].val);
                endcase
            end
        end
    endtask

    initial begin
        int f, g, h;
        rx    = 1'b1;
        reset = 1'b1;

        pushReset(4);
        pushIdle(100, 1'b1);
        addLit(60, 3, 0);
        addLit(60, 2, 8'h00);
        addLit(60, 4, 0);
        addLit(100, 0, 0);

        f = rxQ.size();
        sendFrame(8'hA5, 1'b1, -1);
        pushIdle(20, 1'b1);
        addLit(f + 153, 0, 0);
        addLit(f + 154, 0, 1);
        addLit(f + 154, 2, 8'hA5);
        addLit(f + 155, 0, 0);
        addLit(f + 155, 3, 0);

        g = rxQ.size();
        pushIdle(5, 1'b0);
        pushIdle(40, 1'b1);
        addLit(g + 5, 3, 1);
        addLit(g + 10, 3, 0);
        addLit(g + 10, 4, 0);
        addLit(g + 20, 2, 8'hA5);

        f = rxQ.size();
        sendFrame(8'h3C, 1'b0, -1);
        pushIdle(300, 1'b0);
        h = rxQ.size();
        pushIdle(40, 1'b1);
        addLit(f + 154, 1, 1);
        addLit(f + 154, 0, 0);
        addLit(f + 254, 3, 4);
        addLit(f + 254, 2, 8'hA5);
        addLit(h + 1, 3, 4);
        addLit(h + 3, 3, 0);

        f = rxQ.size();
        sendFrame(8'h00, 1'b1, -1);
        sendFrame(8'hFF, 1'b1, -1);
        sendFrame(8'h55, 1'b1, -1);
        pushIdle(30, 1'b1);
        addLit(f + 154, 0, 1);
        addLit(f + 154, 2, 8'h00);
        addLit(f + 314, 0, 1);
        addLit(f + 314, 2, 8'hFF);
        addLit(f + 474, 0, 1);
        addLit(f + 474, 2, 8'h55);

        f = rxQ.size();
        sendFrame(8'h81, 1'b1, 80);
        addLit(f + 79, 3, 2);
        addLit(f + 80, 3, 0);
        addLit(f + 80, 2, 8'h00);
        pushIdle(40, 1'b1);
        f = rxQ.size();
        sendFrame(8'h81, 1'b1, -1);
        pushIdle(20, 1'b1);
        addLit(f + 154, 0, 1);
        addLit(f + 154, 2, 8'h81);

        for (int i = 0; i < 24; i++) begin
            int choice;
            choice = $urandom_range(9);
            if (choice == 0) begin
                pushIdle($urandom_range(6, 1), 1'b0);
                pushIdle($urandom_range(30, 12), 1'b1);
            end else if (choice == 1) begin
                sendFrame(8'($urandom), 1'b0, -1);
                pushIdle($urandom_range(60, 20), 1'b0);
                pushIdle($urandom_range(20, 4), 1'b1);
            end else begin
                sendFrame(8'($urandom), 1'b1, -1);
                pushIdle($urandom_range(20, 0), 1'b1);
            end
        end
        pushIdle(40, 1'b1);

        buildModel();

        for (int e = 0; e < T; e++) begin
            applyStimulus(e);
            checkOutput(e);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
